// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a single-port, 1-cycle-registered image ROM.
// Optional out-of-range address checking: define ROM_ARB_RANGE_CHECK_EN.
module rom_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned DEPTH      = 307200,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  err0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  err;
    } tag_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > 255 || DEPTH == 0) begin : g_param_check
        $error("rom_read_arbiter: MAX_WAIT must be 1..255 and DEPTH nonzero");
    end

    logic [7:0]            r_wait_cnt;
    tag_t                  r_tag1;
    tag_t                  r_tag2;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_grant;
    port_e                 w_gnt_port;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic                  w_oob;
    logic [7:0]            w_wait_nxt;
    tag_t                  w_tag1_nxt;
    logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;
    logic                  w_rv0;
    logic                  w_rv1;

    // Port 1 overrides only once it has been starved for MAX_WAIT cycles.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req1 && (r_wait_cnt == MAX_WAIT_C)) begin
            w_gnt1 = 1'b1;
        end else if (req0) begin
            w_gnt0 = 1'b1;
        end else if (req1) begin
            w_gnt1 = 1'b1;
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign w_grant    = w_gnt0 | w_gnt1;
    assign w_gnt_port = w_gnt1 ? PORT1 : PORT0;
    assign w_gnt_addr = w_gnt1 ? addr1 : addr0;

`ifdef ROM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    assign w_oob = w_grant && ({1'b0, w_gnt_addr} >= DEPTH_C);
`else
    assign w_oob = 1'b0;
`endif

    always_comb begin
        w_wait_nxt = '0;
        if (req1 && !w_gnt1) begin
            w_wait_nxt = (r_wait_cnt >= MAX_WAIT_C) ? MAX_WAIT_C : r_wait_cnt + 8'd1;
        end
    end

    always_comb begin
        w_tag1_nxt     = '0;
        w_rom_addr_nxt = rom_addr;
        if (w_grant) begin
            w_tag1_nxt.valid = 1'b1;
            w_tag1_nxt.port  = w_gnt_port;
            w_tag1_nxt.err   = w_oob;
            w_rom_addr_nxt   = w_oob ? '0 : w_gnt_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr   <= '0;
            r_wait_cnt <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
        end else begin
            rom_addr   <= w_rom_addr_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_tag1     <= w_tag1_nxt;
            r_tag2     <= r_tag1;
        end
    end

    // Tag stage 2 lines up with the ROM's registered data.
    assign w_rv0   = r_tag2.valid && (r_tag2.port == PORT0);
    assign w_rv1   = r_tag2.valid && (r_tag2.port == PORT1);
    assign rvalid0 = w_rv0;
    assign rvalid1 = w_rv1;
    assign rdata0  = (w_rv0 && !r_tag2.err) ? rom_rdata : '0;
    assign rdata1  = (w_rv1 && !r_tag2.err) ? rom_rdata : '0;

`ifdef ROM_ARB_RANGE_CHECK_EN
    assign err0 = r_tag2.err & w_rv0;
    assign err1 = r_tag2.err & w_rv1;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed scenarios plus random traffic
// against a transaction-level model (denied-cycle count and a 2-deep response line).
module tb_rom_read_arbiter;

    localparam int unsigned AW    = 24;
    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 307200;
    localparam int unsigned MW    = 8;
    localparam int unsigned VW    = 6 + 2*DW + AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_read_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .MAX_WAIT  (MW)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [47:0] h;
        if (a == 24'd5) return 24'hABCDEF;
        h = {24'd0, a} * 48'h9E3779 + 48'h13579B;
        return h[DW-1:0];
    endfunction

    // Registered ROM image
    always @(posedge clk) rom_rdata <= rom_word(rom_addr);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic          port;
        logic          err;
        logic [AW-1:0] addr;
    } ent_t;

    int            m_denied;   // consecutive cycles port 1 has waited
    ent_t          m_s1, m_s2;
    logic [AW-1:0] m_rom_addr;
    logic          e_gnt0, e_gnt1, e_oob, e_rv0, e_rv1, e_err0, e_err1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd0, e_rd1;
    logic [VW-1:0] exp_v, obs_v;

    always_comb begin
        e_gnt1 = req1 && ((m_denied >= int'(MW)) || !req0);
        e_gnt0 = req0 && !e_gnt1;
        e_addr = e_gnt1 ? addr1 : addr0;
`ifdef ROM_ARB_RANGE_CHECK_EN
        e_oob  = (e_gnt0 || e_gnt1) && (int'(e_addr) >= int'(DEPTH));
`else
        e_oob  = 1'b0;
`endif
        e_rv0  = m_s2.v && !m_s2.port;
        e_rv1  = m_s2.v &&  m_s2.port;
        e_err0 = e_rv0 && m_s2.err;
        e_err1 = e_rv1 && m_s2.err;
        e_rd0  = (e_rv0 && !m_s2.err) ? rom_word(m_s2.addr) : '0;
        e_rd1  = (e_rv1 && !m_s2.err) ? rom_word(m_s2.addr) : '0;
        exp_v  = {e_gnt0, e_gnt1, e_rv0, e_rv1, e_err0, e_err1, e_rd0, e_rd1, m_rom_addr};
    end

    assign obs_v = {gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1, rom_addr};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_denied   <= 0;
            m_s1       <= '0;
            m_s2       <= '0;
            m_rom_addr <= '0;
        end else begin
            m_denied <= (req1 && !e_gnt1) ? m_denied + 1 : 0;
            m_s2     <= m_s1;
            if (e_gnt0 || e_gnt1) begin
                m_s1       <= '{v: 1'b1, port: e_gnt1, err: e_oob, addr: e_addr};
                m_rom_addr <= e_oob ? '0 : e_addr;
            end else begin
                m_s1 <= '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return AW'(DEPTH + $urandom_range(0, 100));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        if (obs_v !== '0) begin
            n_fail++; $display("FAIL reset_hold: got %h want 0", obs_v);
        end
        n_checks++;
        tick();
        rst = 1'b0;
        @(negedge clk); #1;
        if (obs_v !== '0) begin
            n_fail++; $display("FAIL reset_release: got %h want 0", obs_v);
        end
        n_checks++;
    endtask

    task automatic test_single();
        req0 = 1'b1; addr0 = 24'h000005;
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL single_model k=%0d: got %h want %h", k, obs_v, exp_v);
            end
            n_checks++;
            if (k == 0 && (gnt0 !== 1'b1 || gnt1 !== 1'b0)) begin
                n_fail++; $display("FAIL single_gnt: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
            end
            if (k == 1 && rom_addr !== 24'd5) begin
                n_fail++; $display("FAIL single_romaddr: got %h want 000005", rom_addr);
            end
            if (k == 2 && (rvalid0 !== 1'b1 || rdata0 !== 24'hABCDEF || rvalid1 !== 1'b0)) begin
                n_fail++; $display("FAIL single_resp: got rv0=%b rd0=%h rv1=%b want 1 abcdef 0",
                                   rvalid0, rdata0, rvalid1);
            end
            if (k < 3) n_checks++;
            tick();
            req0 = 1'b0;
        end
    endtask

    task automatic test_saturated();
        logic g0, g1, want1;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = rand_addr(); addr1 = rand_addr();
        for (int unsigned k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (k < 36) begin
                want1 = ((k % (MW + 1)) == MW);
                if (gnt1 !== want1 || gnt0 !== !want1) begin
                    n_fail++; $display("FAIL sat_pattern k=%0d: got gnt0=%b gnt1=%b want %b %b",
                                       k, gnt0, gnt1, !want1, want1);
                end
                n_checks++;
            end
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL sat_model k=%0d: got %h want %h", k, obs_v, exp_v);
            end
            n_checks++;
            g0 = e_gnt0; g1 = e_gnt1;
            tick();
            if (k >= 35) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (g0) addr0 = AW'($urandom_range(0, DEPTH - 1));
                if (g1) addr1 = AW'($urandom_range(0, DEPTH - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        req1 = 1'b1; addr1 = 24'd10;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL b2b_model k=%0d: got %h want %h", k, obs_v, exp_v);
            end
            n_checks++;
            if (k < 3) begin
                if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_gnt k=%0d: got gnt1=%b want 1", k, gnt1);
                end
                n_checks++;
            end
            if (k >= 2 && k <= 4) begin
                if (rvalid1 !== 1'b1 || rdata1 !== rom_word(AW'(8 + k))) begin
                    n_fail++; $display("FAIL b2b_resp k=%0d: got rv1=%b rd1=%h want 1 %h",
                                       k, rvalid1, rdata1, rom_word(AW'(8 + k)));
                end
                n_checks++;
            end
            tick();
            if (k < 2) addr1 = AW'(11 + k);
            else       req1  = 1'b0;
        end
    endtask

    task automatic test_reset_midflight();
        req0 = 1'b1; addr0 = 24'd3;
        @(negedge clk); #1;
        if (gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL mid_gnt_n: got %b want 1", gnt0);
        end
        n_checks++;
        tick();
        addr0 = 24'd4;
        @(negedge clk); #1;
        if (gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL mid_gnt_n1: got %b want 1", gnt0);
        end
        n_checks++;
        rst = 1'b1; req0 = 1'b0;
        #1;
        if (obs_v !== '0) begin
            n_fail++; $display("FAIL mid_in_reset: got %h want 0", obs_v);
        end
        n_checks++;
        tick();
        rst = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || obs_v !== exp_v) begin
                n_fail++; $display("FAIL mid_after k=%0d: got %h want %h", k, obs_v, exp_v);
            end
            n_checks++;
            tick();
        end
    endtask

    task automatic test_random();
        logic g0, g1;
        for (int unsigned k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL rand_model k=%0d: got %h want %h", k, obs_v, exp_v);
            end
            n_checks++;
            g0 = e_gnt0; g1 = e_gnt1;
            tick();
            if (k >= 396) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (!req0 || g0) begin
                    req0 = ($urandom_range(0, 3) != 0); addr0 = rand_addr();
                end
                if (!req1 || g1) begin
                    req1 = ($urandom_range(0, 1) != 0); addr1 = rand_addr();
                end
            end
        end
    endtask

    task automatic test_range();
        logic [AW-1:0] want_ra;
        logic          want_err;
        logic [DW-1:0] want_rd;
`ifdef ROM_ARB_RANGE_CHECK_EN
        want_ra = '0; want_err = 1'b1; want_rd = '0;
`else
        want_ra = AW'(DEPTH); want_err = 1'b0; want_rd = rom_word(AW'(DEPTH));
`endif
        req1 = 1'b1; addr1 = AW'(DEPTH);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL range_model k=%0d: got %h want %h", k, obs_v, exp_v);
            end
            n_checks++;
            if (k == 0 && gnt1 !== 1'b1) begin
                n_fail++; $display("FAIL range_gnt: got %b want 1", gnt1);
            end
            if (k == 1 && rom_addr !== want_ra) begin
                n_fail++; $display("FAIL range_romaddr: got %h want %h", rom_addr, want_ra);
            end
            if (k == 2 && (rvalid1 !== 1'b1 || err1 !== want_err || rdata1 !== want_rd)) begin
                n_fail++; $display("FAIL range_resp: got rv1=%b err1=%b rd1=%h want 1 %b %h",
                                   rvalid1, err1, rdata1, want_err, want_rd);
            end
            if (k < 3) n_checks++;
            tick();
            req1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturated();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        test_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares the single-port, 1-cycle-registered image ROM between two read requesters.
- Port 0 is the VGA scanout fetch and has default priority. Port 1 is a secondary reader, e.g. a sprite/overlay or debug fetch.
- Issues at most one ROM read per cycle, tags each read with its owner, and returns the data to the owning port with a valid strobe.
- Sits between the requesters and the ROM instance in the VGA subsystem.

Parameters:
- ADDR_WIDTH, 24, width of the ROM address and of both request addresses.
- DATA_WIDTH, 24, width of the ROM data and of both response buses.
- DEPTH, 307200, number of valid ROM words (640*480).
- MAX_WAIT, 8, denied cycles port 1 tolerates before it overrides port 0. Legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  port 0 read request; held with addr0 until gnt0
- addr0  in  ADDR_WIDTH  port 0 word address
- gnt0  out  1  combinational; port 0 request accepted this cycle
- rvalid0  out  1  port 0 response valid
- rdata0  out  DATA_WIDTH  port 0 response data
- err0  out  1  port 0 response carries an out-of-range error
- req1  in  1  port 1 read request; held with addr1 until gnt1
- addr1  in  ADDR_WIDTH  port 1 word address
- gnt1  out  1  combinational; port 1 request accepted this cycle
- rvalid1  out  1  port 1 response valid
- rdata1  out  DATA_WIDTH  port 1 response data
- err1  out  1  port 1 response carries an out-of-range error
- rom_addr  out  ADDR_WIDTH  registered address to the ROM
- rom_rdata  in  DATA_WIDTH  ROM registered read data

Behaviour:
- Reset: rom_addr=0, wait counter=0, both pipeline tag stages cleared. gnt0/gnt1 follow requests combinationally; rvalid0/1, err0/1 = 0; rdata0/1 = 0.
- Grant rule, per cycle:
  - If req1 and wait_cnt==MAX_WAIT: gnt1=1.
  - Else if req0: gnt0=1.
  - Else if req1: gnt1=1.
  - Never both grants high. No grant when no request.
- Wait counter (8 bit):
  - +1 on each cycle with req1=1 and gnt1=0, saturating at MAX_WAIT.
  - Clears to 0 on gnt1 or req1=0.
- Handshake: a request is consumed on the edge ending a cycle with gnt=1. The requester may present a new address in the next cycle (back-to-back allowed). Changing addr while req=1 and gnt=0 is illegal.
- Pipeline, granted in cycle N:
  - Edge ending N: rom_addr<=granted addr; tag stage 1 <= {valid, port, err}.
  - Edge ending N+1: ROM registers data; tag stage 2 <= tag stage 1.
  - Cycle N+2: rvalidX=1 for the owning port; rdataX=rom_rdata.
  - Fixed latency 2 cycles from grant to response. Throughput one read per cycle.
- When not granting, rom_addr holds its previous value. Tag stage 1 loads valid=0.
- rdataX = rom_rdata when rvalidX=1, else 0. errX = tag err & rvalidX.
- Responses are returned in grant order; no reordering.
- Simultaneous req0 and req1 with wait_cnt<MAX_WAIT: port 0 wins and the counter increments.
- Both ports saturated: repeating pattern of MAX_WAIT port-0 grants, then 1 port-1 grant.
- Reset asserted mid-operation: in-flight reads are discarded immediately. No rvalid appears after reset releases until a new grant is made.

Optional Feature:
- Macro: ROM_ARB_RANGE_CHECK_EN.
- Defined:
  - A granted address >= DEPTH still consumes its slot and gets its grant.
  - rom_addr is loaded with 0 instead of the address, and the tag err bit is set.
  - The response arrives at the normal latency with rvalidX=1, errX=1, rdataX=0.
- Undefined: addresses pass through unchecked; err0/err1 are tied 0.

Test Plan:
- Reset then req0=1, addr0=0x000005 held one cycle, ROM word 5=0xABCDEF -> gnt0 same cycle; rom_addr=5 next cycle; rvalid0=1, rdata0=0xABCDEF two cycles after grant; rvalid1 stays 0.
- req0 and req1 continuously high, MAX_WAIT=8 -> grant sequence 0,0,0,0,0,0,0,0,1 repeating; responses in matching order, each two cycles after its grant.
- req1 alone with addresses 10,11,12 back-to-back -> gnt1 three consecutive cycles; rvalid1 three consecutive cycles with ROM[10..12]; wait counter stays 0.
- Grants issued in cycles N and N+1, rst pulsed in cycle N+1 -> no rvalid0/rvalid1 ever observed for those reads; all outputs 0 during reset.
- With ROM_ARB_RANGE_CHECK_EN, req1 addr1=307200 -> gnt1; rom_addr=0; two cycles later rvalid1=1, err1=1, rdata1=0. Without the macro, err1 stays 0.
